// File: rtl/tick_pwm_generator.sv
// Tick-driven PWM: synchronises a slow divider toggle, turns its edges into ticks and steps a
// period/duty counter. Define TICK_BOTH_EDGES_EN to tick on both edges of tick_in (default: rising only).
module tick_pwm_generator #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] period_in,
    input  logic [CNT_W-1:0] duty_in,
    output logic             pwm_out,
    output logic             period_end,
    output logic             tick_seen
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   synced, tick;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       period_act_q, period_act_d;
    logic [CNT_W-1:0]       duty_act_q, duty_act_d;
    logic [CNT_W-1:0]       shadow_period_q, shadow_period_d;
    logic [CNT_W-1:0]       shadow_duty_q, shadow_duty_d;
    logic                   pending_q, pending_d;
    logic                   pwm_q, pwm_d;
    logic                   period_end_q, period_end_d;
    logic                   tick_seen_q, tick_seen_d;
    logic                   apply_cfg;

    // tick_in is asynchronous: it only ever feeds the first synchroniser flop.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], tick_in};
        synced      = sync_q[SYNC_STAGES-1];
        prev_d      = synced;
`ifdef TICK_BOTH_EDGES_EN
        tick        = synced ^ prev_q;
`else
        tick        = synced & ~prev_q;
`endif
        tick_seen_d = tick;
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        period_act_d    = period_act_q;
        duty_act_d      = duty_act_q;
        shadow_period_d = shadow_period_q;
        shadow_duty_d   = shadow_duty_q;
        pending_d       = pending_q;
        period_end_d    = 1'b0;
        apply_cfg       = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                apply_cfg = pending_q;
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == period_act_q) begin
                        cnt_d        = '0;
                        period_end_d = 1'b1;
                        apply_cfg    = pending_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Capture only happens with the shadow empty, so it never collides with an apply.
        if (apply_cfg) begin
            period_act_d = shadow_period_q;
            duty_act_d   = shadow_duty_q;
            pending_d    = 1'b0;
        end
        if (cfg_valid && !pending_q) begin
            shadow_period_d = period_in;
            shadow_duty_d   = duty_in;
            pending_d       = 1'b1;
        end

        // Uses next-cycle count and duty so the output lines up with the counter after a reload.
        pwm_d = (state_d == RUN) && (cnt_d < duty_act_d);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            sync_q          <= '0;
            prev_q          <= 1'b0;
            cnt_q           <= '0;
            period_act_q    <= '0;
            duty_act_q      <= '0;
            shadow_period_q <= '0;
            shadow_duty_q   <= '0;
            pending_q       <= 1'b0;
            pwm_q           <= 1'b0;
            period_end_q    <= 1'b0;
            tick_seen_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            sync_q          <= sync_d;
            prev_q          <= prev_d;
            cnt_q           <= cnt_d;
            period_act_q    <= period_act_d;
            duty_act_q      <= duty_act_d;
            shadow_period_q <= shadow_period_d;
            shadow_duty_q   <= shadow_duty_d;
            pending_q       <= pending_d;
            pwm_q           <= pwm_d;
            period_end_q    <= period_end_d;
            tick_seen_q     <= tick_seen_d;
        end
    end

    assign cfg_ready  = ~pending_q;
    assign pwm_out    = pwm_q;
    assign period_end = period_end_q;
    assign tick_seen  = tick_seen_q;

endmodule

// File: tb/tb_tick_pwm_generator.sv
// Directed bench for tick_pwm_generator: reset, tick latency, PWM waveforms, deferred/colliding config.
// Expected waveforms are hand-derived; builds with or without TICK_BOTH_EDGES_EN.
module tb_tick_pwm_generator;

    localparam int CNT_W       = 8;
    localparam int SYNC_STAGES = 2;
`ifdef TICK_BOTH_EDGES_EN
    localparam bit BOTH = 1'b1;
`else
    localparam bit BOTH = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             tick_in;
    logic             enable;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] period_in;
    logic [CNT_W-1:0] duty_in;
    logic             pwm_out;
    logic             period_end;
    logic             tick_seen;

    int n_checks = 0;
    int n_fails  = 0;
    int pe_cnt   = 0;
    int pe_mark;

    tick_pwm_generator #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_in    (tick_in),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .period_in  (period_in),
        .duty_in    (duty_in),
        .pwm_out    (pwm_out),
        .period_end (period_end),
        .tick_seen  (tick_seen)
    );

    always #5 clk = ~clk;

    // Counts negedges with period_end high; a pulse wider than one cycle inflates the count.
    always @(negedge clk) if (period_end) pe_cnt <= pe_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One counted tick; optionally offers a config exactly on the edge the tick is counted.
    task automatic give_tick(input bit cfg_on_tick = 1'b0,
                             input logic [CNT_W-1:0] p = '0,
                             input logic [CNT_W-1:0] d = '0);
        if (!BOTH && tick_in) begin
            tick_in = 1'b0;
            repeat (6) @(negedge clk);
        end
        tick_in = ~tick_in;
        repeat (2) @(negedge clk);
        if (cfg_on_tick) begin
            period_in = p;
            duty_in   = d;
            cfg_valid = 1'b1;
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic cfg_write(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] d);
        period_in = p;
        duty_in   = d;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic restart(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] d);
        enable = 1'b0;
        @(negedge clk);
        cfg_write(p, d);
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
    endtask

    bit basic_exp [10] = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 1};
    bit defer_exp [7]  = '{0, 0, 0, 1, 0, 0, 1};
    bit coll_exp  [7]  = '{0, 0, 1, 1, 1, 0, 1};

    initial begin
        rst = 1'b1; tick_in = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
        period_in = '0; duty_in = '0;
        repeat (3) @(negedge clk);
        check("rst_pwm", pwm_out, 1'b0);
        check("rst_period_end", period_end, 1'b0);
        check("rst_tick_seen", tick_seen, 1'b0);
        check("rst_cfg_ready", cfg_ready, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // Tick latency: rise seen on the third edge, one cycle wide; fall only in both-edges build.
        tick_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("lat_rise_early", tick_seen, 1'b0);
        @(posedge clk);
        #1 check("lat_rise_on_time", tick_seen, 1'b1);
        @(posedge clk);
        #1 check("lat_rise_width", tick_seen, 1'b0);
        @(negedge clk);
        tick_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("lat_fall", tick_seen, BOTH);
        repeat (3) @(negedge clk);
        check("idle_pwm", pwm_out, 1'b0);

        // Config in IDLE applies the cycle after capture.
        cfg_write(8'd4, 8'd2);
        check("cfg_capture_ready", cfg_ready, 1'b0);
        @(negedge clk);
        check("cfg_idle_apply_ready", cfg_ready, 1'b1);
        enable = 1'b1;
        @(negedge clk);
        check("run_entry_pwm", pwm_out, 1'b1);

        // P=4 D=2: two high ticks, three low.
        pe_mark = pe_cnt;
        for (int i = 0; i < 10; i++) begin
            give_tick();
            check($sformatf("basic_pwm_%0d", i), pwm_out, basic_exp[i]);
        end
        check("basic_period_end_count", pe_cnt - pe_mark, 2);

        // Deferred update issued at cnt=1.
        give_tick();
        check("defer_cnt1_pwm", pwm_out, 1'b1);
        cfg_write(8'd2, 8'd1);
        check("defer_ready_low", cfg_ready, 1'b0);
        pe_mark = pe_cnt;
        for (int i = 0; i < 7; i++) begin
            give_tick();
            check($sformatf("defer_pwm_%0d", i), pwm_out, defer_exp[i]);
            if (i == 2) check("defer_ready_before_wrap", cfg_ready, 1'b0);
            if (i == 3) check("defer_ready_after_wrap", cfg_ready, 1'b1);
        end
        check("defer_period_end_count", pe_cnt - pe_mark, 2);

        // Collision: handshake on the wrap edge; a second offer while busy is dropped.
        give_tick();
        check("coll_pre1_pwm", pwm_out, 1'b0);
        give_tick();
        check("coll_pre2_pwm", pwm_out, 1'b0);
        pe_mark = pe_cnt;
        give_tick(1'b1, 8'd3, 8'd3);
        check("coll_wrap_pwm", pwm_out, 1'b1);
        check("coll_ready_low", cfg_ready, 1'b0);
        cfg_write(8'd1, 8'd0);
        @(negedge clk);
        check("coll_ignored_ready", cfg_ready, 1'b0);
        for (int i = 0; i < 7; i++) begin
            give_tick();
            check($sformatf("coll_pwm_%0d", i), pwm_out, coll_exp[i]);
            if (i == 2) check("coll_ready_after_wrap", cfg_ready, 1'b1);
        end
        check("coll_period_end_count", pe_cnt - pe_mark, 3);

        enable = 1'b0;
        @(negedge clk);
        check("disable_pwm", pwm_out, 1'b0);

        // Boundaries.
        restart(8'd4, 8'd0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("duty0_pwm_%0d", i), pwm_out, 1'b0);
            give_tick();
        end
        restart(8'd4, 8'd9);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("duty_over_pwm_%0d", i), pwm_out, 1'b1);
            give_tick();
        end
        restart(8'd0, 8'd1);
        pe_mark = pe_cnt;
        for (int i = 0; i < 4; i++) begin
            give_tick();
            check($sformatf("p0_pwm_%0d", i), pwm_out, 1'b1);
        end
        check("p0_period_end_count", pe_cnt - pe_mark, 4);

        // Asynchronous reset mid-run at cnt=3 with a pending config.
        restart(8'd4, 8'd4);
        repeat (3) give_tick();
        check("pre_reset_pwm", pwm_out, 1'b1);
        cfg_write(8'd1, 8'd1);
        check("pre_reset_ready", cfg_ready, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_pwm", pwm_out, 1'b0);
        check("mid_rst_period_end", period_end, 1'b0);
        check("mid_rst_tick_seen", tick_seen, 1'b0);
        check("mid_rst_cfg_ready", cfg_ready, 1'b1);
        enable  = 1'b0;
        tick_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        restart(8'd4, 8'd4);
        check("restart_cnt0_pwm", pwm_out, 1'b1);
        give_tick();
        check("restart_cnt1_pwm", pwm_out, 1'b1);
        repeat (3) give_tick();
        check("restart_cnt4_pwm", pwm_out, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
